// File: rtl/stepper_phase_decoder_pkg.sv
// Shared types and pattern constants for the two-channel stepper phase decoder.
package stepper_pkg;

  typedef logic [2:0] idx_t;
  typedef logic [3:0] pat_t;

  // Half-step patterns {A,B,C,D}, active-low coil lines, index 0..7
  localparam pat_t PAT_I0   = 4'b0111;
  localparam pat_t PAT_I1   = 4'b0011;
  localparam pat_t PAT_I2   = 4'b1011;
  localparam pat_t PAT_I3   = 4'b1001;
  localparam pat_t PAT_I4   = 4'b1101;
  localparam pat_t PAT_I5   = 4'b1100;
  localparam pat_t PAT_I6   = 4'b1110;
  localparam pat_t PAT_I7   = 4'b0110;
  localparam pat_t PAT_IDLE = 4'b1010;

  typedef struct packed {
    logic legal;
    logic idle;
    idx_t idx;
  } dec_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } chan_state_e;

  // Classify a coil pattern as legal (with its half-step index), idle, or illegal
  function automatic dec_t decode_pat(input pat_t p);
    dec_t d;
    d = '{legal: 1'b1, idle: 1'b0, idx: 3'd0};
    case (p)
      PAT_I0:   d.idx = 3'd0;
      PAT_I1:   d.idx = 3'd1;
      PAT_I2:   d.idx = 3'd2;
      PAT_I3:   d.idx = 3'd3;
      PAT_I4:   d.idx = 3'd4;
      PAT_I5:   d.idx = 3'd5;
      PAT_I6:   d.idx = 3'd6;
      PAT_I7:   d.idx = 3'd7;
      PAT_IDLE: begin
        d.legal = 1'b0;
        d.idle  = 1'b1;
      end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// Bundle of phase inputs, clear strobes and per-channel status outputs.
interface stepper_phase_decoder_if #(
  parameter int POS_W    = 16,
  parameter int PERIOD_W = 20
);
  logic [3:0]                ph0;
  logic [3:0]                ph1;
  logic [1:0]                pos_clear;
  logic [1:0]                err_clear;
  logic [1:0]                locked;
  logic [1:0]                step_pulse;
  logic [1:0]                step_dir;
  logic signed [POS_W-1:0]   pos0;
  logic signed [POS_W-1:0]   pos1;
  logic [PERIOD_W-1:0]       period0;
  logic [PERIOD_W-1:0]       period1;
  logic [1:0]                period_valid;
  logic [1:0]                err_illegal;
  logic [1:0]                err_skip;

  modport master (
    output ph0, ph1, pos_clear, err_clear,
    input  locked, step_pulse, step_dir, pos0, pos1, period0, period1,
           period_valid, err_illegal, err_skip
  );

  modport slave (
    input  ph0, ph1, pos_clear, err_clear,
    output locked, step_pulse, step_dir, pos0, pos1, period0, period1,
           period_valid, err_illegal, err_skip
  );
endinterface

// File: rtl/stepper_phase_decoder_chan.sv
// One decoder channel: synchronizer, stability filter, lock FSM, position and period counters.
module stepper_phase_chan
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int PERIOD_W      = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  pat_t                     ph_i,
  input  logic                     pos_clear_i,
  input  logic                     err_clear_i,
  output logic                     locked_o,
  output logic                     step_pulse_o,
  output logic                     step_dir_o,
  output logic signed [POS_W-1:0]  pos_o,
  output logic [PERIOD_W-1:0]      period_o,
  output logic                     period_valid_o,
  output logic                     err_illegal_o,
  output logic                     err_skip_o
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pat_t                    sync_q [SYNC_STAGES];
  pat_t                    cand_q, acc_q;
  logic [RUN_W-1:0]        run_q;
  chan_state_e             state_q, state_d;
  idx_t                    idx_q, idx_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    dir_q, dir_d, pulse_q, pulse_d;
  logic [PERIOD_W-1:0]     cnt_q, cnt_d, period_q, period_d;
  logic                    pvalid_q, pvalid_d, seen_q, seen_d;
  logic                    ill_q, ill_d, skip_q, skip_d;
  logic                    new_ill, new_skip;
  pat_t                    sync_out;
  logic                    accept;
  dec_t                    dec;
  idx_t                    delta;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // A held candidate is only evaluated when it differs from the last accepted pattern
  assign accept   = (run_q == RUN_MAX) && (cand_q != acc_q);
  assign dec      = decode_pat(cand_q);
  assign delta    = dec.idx - idx_q;

  // Metastability synchronizer chain for the asynchronous coil lines
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PAT_IDLE;
    end else begin
      sync_q[0] <= ph_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Run-length filter: count consecutive identical synchronized samples
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= PAT_IDLE;
      acc_q  <= PAT_IDLE;
      run_q  <= '0;
    end else begin
      cand_q <= sync_out;
      if (sync_out != cand_q) run_q <= RUN_W'(1);
      else if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
      if (accept) acc_q <= cand_q;
    end
  end

  // Lock FSM next state, step decode, position/period/error updates
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    pulse_d  = 1'b0;
    period_d = period_q;
    pvalid_d = pvalid_q;
    seen_d   = seen_q;
    cnt_d    = (state_q == ST_LOCKED) ? sat_inc(cnt_q) : '0;
    new_ill  = 1'b0;
    new_skip = 1'b0;
    if (accept) begin
      if (state_q == ST_UNLOCKED) begin
        if (dec.legal) begin
          state_d = ST_LOCKED;
          idx_d   = dec.idx;
          seen_d  = 1'b0;
        end else if (!dec.idle) begin
          new_ill = 1'b1;
        end
      end else if (dec.legal) begin
        if (delta == 3'd1 || delta == 3'd7) begin
          pos_d    = (delta == 3'd1) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          dir_d    = (delta == 3'd1);
          pulse_d  = 1'b1;
          period_d = sat_inc(cnt_q);
          cnt_d    = '0;
          pvalid_d = pvalid_q | seen_q;
          seen_d   = 1'b1;
        end else begin
          new_skip = 1'b1;
        end
        idx_d = dec.idx;
      end else begin
        state_d  = ST_UNLOCKED;
        cnt_d    = '0;
        pvalid_d = 1'b0;
        seen_d   = 1'b0;
        new_ill  = !dec.idle;
      end
    end
    if (pos_clear_i) pos_d = '0;
    // A new error wins over a simultaneous clear
    ill_d  = (ill_q  & ~err_clear_i) | new_ill;
    skip_d = (skip_q & ~err_clear_i) | new_skip;
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      idx_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      seen_q   <= 1'b0;
      ill_q    <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      seen_q   <= seen_d;
      ill_q    <= ill_d;
      skip_q   <= skip_d;
    end
  end

  assign locked_o       = (state_q == ST_LOCKED);
  assign step_pulse_o   = pulse_q;
  assign step_dir_o     = dir_q;
  assign pos_o          = pos_q;
  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
  assign err_illegal_o  = ill_q;
  assign err_skip_o     = skip_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Two-channel stepper phase decoder top: two independent channels mapped onto the bus.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int PERIOD_W      = 20
) (
  input logic                clk,
  input logic                reset,
  stepper_phase_decoder_if.slave bus
);

  logic lock0, lock1, pls0, pls1, dir0, dir1, pv0, pv1, ill0, ill1, skp0, skp1;

  stepper_phase_chan #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
    .POS_W(POS_W), .PERIOD_W(PERIOD_W)
  ) u_chan0 (
    .clk(clk), .reset(reset), .ph_i(bus.ph0),
    .pos_clear_i(bus.pos_clear[0]), .err_clear_i(bus.err_clear[0]),
    .locked_o(lock0), .step_pulse_o(pls0), .step_dir_o(dir0),
    .pos_o(bus.pos0), .period_o(bus.period0), .period_valid_o(pv0),
    .err_illegal_o(ill0), .err_skip_o(skp0)
  );

  stepper_phase_chan #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
    .POS_W(POS_W), .PERIOD_W(PERIOD_W)
  ) u_chan1 (
    .clk(clk), .reset(reset), .ph_i(bus.ph1),
    .pos_clear_i(bus.pos_clear[1]), .err_clear_i(bus.err_clear[1]),
    .locked_o(lock1), .step_pulse_o(pls1), .step_dir_o(dir1),
    .pos_o(bus.pos1), .period_o(bus.period1), .period_valid_o(pv1),
    .err_illegal_o(ill1), .err_skip_o(skp1)
  );

  assign bus.locked       = {lock1, lock0};
  assign bus.step_pulse   = {pls1, pls0};
  assign bus.step_dir     = {dir1, dir0};
  assign bus.period_valid = {pv1, pv0};
  assign bus.err_illegal  = {ill1, ill0};
  assign bus.err_skip     = {skp1, skp0};

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench for stepper_phase_decoder: event-level reference model, decoupled step monitor.
module tb_stepper_phase_decoder;
  import stepper_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stepper_phase_decoder_if #(.POS_W(16), .PERIOD_W(20)) bus ();

  stepper_phase_decoder #(
    .SYNC_STAGES(2), .STABLE_CYCLES(4), .POS_W(16), .PERIOD_W(20)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [3:0] ph_v0, ph_v1;
  logic       pclr0, pclr1, eclr0, eclr1;
  assign bus.ph0       = ph_v0;
  assign bus.ph1       = ph_v1;
  assign bus.pos_clear = {pclr1, pclr0};
  assign bus.err_clear = {eclr1, eclr0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          t;
    logic        dir;
    logic [15:0] pos;
    logic        pv;
    int          per;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [3:0] LEG [8] = '{4'b0111, 4'b0011, 4'b1011, 4'b1001,
                          4'b1101, 4'b1100, 4'b1110, 4'b0110};
  localparam logic [3:0] IDLE = 4'b1010;

  // Reference model state per channel
  logic [3:0]  m_acc  [2];
  bit          m_lock [2];
  int          m_idx  [2];
  logic [15:0] m_pos  [2];
  bit          m_dir  [2];
  int          m_ref  [2];
  int          m_nstep[2];
  bit          m_pv   [2];
  bit          m_ill  [2];
  bit          m_skip [2];

  function automatic int lookup(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (LEG[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input int ch, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0h required=%0h (t=%0d)", nm, ch, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] get_pos(input int ch);
    logic [15:0] p;
    p = (ch == 0) ? bus.pos0 : bus.pos1;
    return p;
  endfunction

  function automatic logic [19:0] get_per(input int ch);
    return (ch == 0) ? bus.period0 : bus.period1;
  endfunction

  task automatic set_ph(input int ch, input logic [3:0] p);
    if (ch == 0) ph_v0 = p; else ph_v1 = p;
  endtask

  task automatic set_clr(input int ch, input logic pc, input logic ec);
    if (ch == 0) begin pclr0 = pc; eclr0 = ec; end
    else begin pclr1 = pc; eclr1 = ec; end
  endtask

  // Apply the rules to a pattern held long enough to be accepted; k = change time
  task automatic model_event(input int ch, input logic [3:0] p, input int k, input bit pc, input bit ec);
    int li, d;
    bit nill, nskip, step;
    exp_t e;
    nill = 0; nskip = 0; step = 0;
    e = '{t: 0, dir: 1'b0, pos: 16'h0, pv: 1'b0, per: 0};
    if (p != m_acc[ch]) begin
      li = lookup(p);
      m_acc[ch] = p;
      if (!m_lock[ch]) begin
        if (li >= 0) begin
          m_lock[ch] = 1; m_idx[ch] = li; m_ref[ch] = k; m_nstep[ch] = 0;
        end else if (p != IDLE) nill = 1;
      end else if (li >= 0) begin
        d = (li - m_idx[ch] + 8) % 8;
        if (d == 1 || d == 7) begin
          step = 1;
          if (d == 1) m_pos[ch] = m_pos[ch] + 16'd1;
          else        m_pos[ch] = m_pos[ch] - 16'd1;
          m_dir[ch] = (d == 1);
          e.per = k - m_ref[ch];
          m_ref[ch] = k;
          m_nstep[ch]++;
          m_pv[ch] = (m_nstep[ch] >= 2);
        end else nskip = 1;
        m_idx[ch] = li;
      end else begin
        m_lock[ch] = 0; m_pv[ch] = 0;
        if (p != IDLE) nill = 1;
      end
    end
    if (pc) m_pos[ch] = 16'h0;
    m_ill[ch]  = (m_ill[ch]  & !ec) | nill;
    m_skip[ch] = (m_skip[ch] & !ec) | nskip;
    if (step) begin
      e.t = k + 7; e.dir = m_dir[ch]; e.pos = m_pos[ch]; e.pv = m_pv[ch];
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Drive a pattern for 'hold' cycles; clears land on the edge where the event registers
  task automatic apply(input int ch, input logic [3:0] p, input int hold, input bit pc, input bit ec);
    int k;
    k = cyc;
    set_ph(ch, p);
    model_event(ch, p, k, pc, ec);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      set_clr(ch, pc && (cyc == k + 6), ec && (cyc == k + 6));
    end
    set_clr(ch, 1'b0, 1'b0);
    check("locked", ch, 32'(bus.locked[ch]), 32'(m_lock[ch]));
    check("pos", ch, 32'(get_pos(ch)), 32'(m_pos[ch]));
    check("err_illegal", ch, 32'(bus.err_illegal[ch]), 32'(m_ill[ch]));
    check("err_skip", ch, 32'(bus.err_skip[ch]), 32'(m_skip[ch]));
    check("period_valid", ch, 32'(bus.period_valid[ch]), 32'(m_pv[ch]));
    check("step_dir", ch, 32'(bus.step_dir[ch]), 32'(m_dir[ch]));
  endtask

  // Short excursion that must be filtered out, then return to the accepted pattern
  task automatic glitch(input int ch, input logic [3:0] p, input int len);
    set_ph(ch, p);
    repeat (len) begin @(posedge clk); #1; end
    set_ph(ch, m_acc[ch]);
  endtask

  task automatic rand_seg(input int ch);
    int r, hold;
    logic [3:0] p;
    bit pc, ec;
    r    = $urandom_range(0, 99);
    hold = $urandom_range(8, 40);
    pc   = ($urandom_range(0, 9) == 0);
    ec   = ($urandom_range(0, 9) == 0);
    if (!m_lock[ch] && r < 65) p = LEG[$urandom_range(0, 7)];
    else if (r < 55) p = LEG[(m_idx[ch] + (($urandom_range(0, 1) == 1) ? 1 : 7)) % 8];
    else if (r < 65) p = LEG[(m_idx[ch] + $urandom_range(2, 6)) % 8];
    else if (r < 72) p = IDLE;
    else if (r < 78) begin
      p = 4'b1111;
      for (int i = 0; i < 16; i++) begin
        p = 4'($urandom_range(0, 15));
        if (lookup(p) < 0 && p != IDLE) break;
      end
      if (lookup(p) >= 0 || p == IDLE) p = 4'b1111;
    end else if (r < 88) begin
      glitch(ch, 4'($urandom_range(0, 15)), $urandom_range(1, 3));
      p = m_acc[ch];
    end else p = LEG[$urandom_range(0, 7)];
    apply(ch, p, hold, pc, ec);
  endtask

  task automatic mon(input int ch);
    exp_t e;
    if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_step ch%0d actual=pulse required=none (t=%0d)", ch, cyc);
    end else begin
      e = (ch == 0) ? q0.pop_front() : q1.pop_front();
      check("step_time", ch, 32'(cyc), 32'(e.t));
      check("step_pos", ch, 32'(get_pos(ch)), 32'(e.pos));
      check("step_dir_at_pulse", ch, 32'(bus.step_dir[ch]), 32'(e.dir));
      check("step_pvalid", ch, 32'(bus.period_valid[ch]), 32'(e.pv));
      if (e.pv) check("period", ch, 32'(get_per(ch)), 32'(e.per));
    end
  endtask

  // Monitor: every step pulse is matched against the next expected step
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.step_pulse[0]) mon(0);
      if (bus.step_pulse[1]) mon(1);
    end
  end

  task automatic directed_ch0();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) apply(0, LEG[i], 10, 0, 0);
    check("fwd_pos15", 0, 32'(get_pos(0)), 32'd15);
    check("fwd_dir", 0, 32'(bus.step_dir[0]), 32'd1);
    apply(0, IDLE, 10, 0, 0);
    apply(0, LEG[0], 10, 1, 0);
    apply(0, LEG[7], 10, 0, 0);
    check("rev_pos", 0, 32'(get_pos(0)), 32'h0000FFFF);
    check("rev_dir", 0, 32'(bus.step_dir[0]), 32'd0);
    apply(0, LEG[0], 10, 0, 0);
    apply(0, LEG[1], 10, 0, 0);
    glitch(0, LEG[2], 2);
    apply(0, LEG[1], 10, 0, 0);
    check("glitch_pos", 0, 32'(get_pos(0)), 32'd1);
    apply(0, LEG[0], 10, 0, 0);
    apply(0, LEG[3], 10, 0, 0);
    check("skip_flag", 0, 32'(bus.err_skip[0]), 32'd1);
    check("skip_pos", 0, 32'(get_pos(0)), 32'd0);
    apply(0, LEG[4], 10, 0, 0);
    check("after_skip_pos", 0, 32'(get_pos(0)), 32'd1);
    apply(0, 4'b0000, 10, 0, 0);
    check("illegal_flag", 0, 32'(bus.err_illegal[0]), 32'd1);
    check("illegal_unlock", 0, 32'(bus.locked[0]), 32'd0);
    apply(0, IDLE, 10, 0, 1);
    apply(0, 4'b1111, 10, 0, 1);
    check("clear_vs_new_err", 0, 32'(bus.err_illegal[0]), 32'd1);
    apply(0, LEG[0], 10, 0, 1);
    apply(0, LEG[1], 100, 0, 0);
    apply(0, LEG[2], 100, 0, 0);
    apply(0, LEG[3], 100, 0, 0);
    check("period100", 0, 32'(bus.period0), 32'd100);
    check("period_valid2", 0, 32'(bus.period_valid[0]), 32'd1);
    apply(0, LEG[4], 100, 1, 0);
    check("pos_clear_step", 0, 32'(get_pos(0)), 32'd0);
    apply(0, LEG[5], 100, 0, 0);
    for (int i = 0; i < 40; i++) rand_seg(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish (t=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ph_v0 = IDLE; ph_v1 = IDLE;
    pclr0 = 0; pclr1 = 0; eclr0 = 0; eclr1 = 0;
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = IDLE; m_lock[c] = 0; m_idx[c] = 0; m_pos[c] = 16'h0; m_dir[c] = 0;
      m_ref[c] = 0; m_nstep[c] = 0; m_pv[c] = 0; m_ill[c] = 0; m_skip[c] = 0;
    end
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_locked", 0, 32'(bus.locked), 32'd0);
    check("rst_pulse", 0, 32'(bus.step_pulse), 32'd0);
    check("rst_dir", 0, 32'(bus.step_dir), 32'd0);
    check("rst_pos0", 0, 32'(get_pos(0)), 32'd0);
    check("rst_pos1", 1, 32'(get_pos(1)), 32'd0);
    check("rst_period0", 0, 32'(bus.period0), 32'd0);
    check("rst_pvalid", 0, 32'(bus.period_valid), 32'd0);
    check("rst_err", 0, 32'({bus.err_illegal, bus.err_skip}), 32'd0);
    fork
      directed_ch0();
      begin
        for (int i = 0; i < 90; i++) rand_seg(1);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("q0_drained", 0, 32'(q0.size()), 32'd0);
    check("q1_drained", 1, 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
